// File: rtl/injetor_seq.sv
// Parity-word error injector: registers the word stream with one cycle of latency and flips
// one or two bits of selected words (off / single-shot / periodic / pseudo-random).
module injetor_seq #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned IDXW  = $clog2(WIDTH),
  parameter int unsigned CNTW  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  entrada,
  input  logic              entrada_valida,
  input  logic [1:0]        modo,
  input  logic [IDXW-1:0]   n,
  input  logic              duplo,
  input  logic              disparo,
  input  logic [CNTW-1:0]   periodo,
  input  logic              limpa_contagem,
  output logic [WIDTH-1:0]  saida,
  output logic              saida_valida,
  output logic              injetado,
  output logic [CNTW-1:0]   contagem_erros
);

  typedef enum logic [1:0] {ModoOff, ModoSingle, ModoPeriod, ModoRandom} modo_e;

  localparam logic [15:0]   LfsrSeed = 16'hACE1;
  localparam logic [IDXW:0] WidthExt = (IDXW+1)'(WIDTH);

  logic              armed_q, armed_d;
  logic [CNTW-1:0]   per_q, per_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [WIDTH-1:0]  saida_q, saida_d;
  logic              valida_q, valida_d;
  logic              inj_q, inj_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;

  logic              fire;
  logic [IDXW-1:0]   idx;
  logic [IDXW:0]     rnd_ext;
  logic [IDXW:0]     idx_ext;
  logic [IDXW:0]     idx_nxt;
  logic              in_range;
  logic [WIDTH-1:0]  mask;
  logic              inject;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      armed_q  <= 1'b0;
      per_q    <= '0;
      lfsr_q   <= LfsrSeed;
      saida_q  <= '0;
      valida_q <= 1'b0;
      inj_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      armed_q  <= armed_d;
      per_q    <= per_d;
      lfsr_q   <= lfsr_d;
      saida_q  <= saida_d;
      valida_q <= valida_d;
      inj_q    <= inj_d;
      cnt_q    <= cnt_d;
    end
  end

  // Injection decision and mode state.
  always_comb begin
    armed_d = armed_q;
    per_d   = per_q;
    fire    = 1'b0;
    idx     = n;
    // Fold the raw LFSR index back into 0..WIDTH-1.
    rnd_ext = {1'b0, lfsr_q[IDXW-1:0]};
    if (rnd_ext >= WidthExt) begin
      rnd_ext = rnd_ext - WidthExt;
    end
    unique case (modo_e'(modo))
      ModoOff: begin
        armed_d = 1'b0;
        per_d   = '0;
      end
      ModoSingle: begin
        per_d = '0;
        if (disparo) begin
          armed_d = 1'b1;
        end
        if (entrada_valida && (armed_q || disparo)) begin
          fire    = 1'b1;
          armed_d = 1'b0;
        end
      end
      ModoPeriod: begin
        armed_d = 1'b0;
        if (entrada_valida) begin
          if (periodo == '0) begin
            per_d = '0;
          end else if (per_q >= periodo - CNTW'(1)) begin
            fire  = 1'b1;
            per_d = '0;
          end else begin
            per_d = per_q + CNTW'(1);
          end
        end
      end
      ModoRandom: begin
        armed_d = 1'b0;
        per_d   = '0;
        fire    = entrada_valida && (lfsr_q[15:12] == 4'd0);
        idx     = rnd_ext[IDXW-1:0];
      end
      default: ;
    endcase

    lfsr_d = lfsr_q;
    if (entrada_valida) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  // Bit mask: idx and, for double errors, its cyclic neighbour.
  always_comb begin
    idx_ext  = {1'b0, idx};
    in_range = idx_ext < WidthExt;
    idx_nxt  = (idx_ext == WidthExt - (IDXW+1)'(1)) ? '0 : idx_ext + (IDXW+1)'(1);
    mask     = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      mask[i] = in_range && ((idx_ext == (IDXW+1)'(i)) || (duplo && (idx_nxt == (IDXW+1)'(i))));
    end
    inject = fire && in_range;
  end

  always_comb begin
    saida_d  = saida_q;
    valida_d = entrada_valida;
    inj_d    = 1'b0;
    if (entrada_valida) begin
      saida_d = inject ? (entrada ^ mask) : entrada;
      inj_d   = inject;
    end
    cnt_d = cnt_q;
    if (limpa_contagem) begin
      cnt_d = '0;
    end else if (inject && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  assign saida          = saida_q;
  assign saida_valida   = valida_q;
  assign injetado       = inj_q;
  assign contagem_erros = cnt_q;

endmodule

// File: tb/tb_injetor_seq.sv
// Bench for injetor_seq: directed steps plus random traffic against a behavioural model.
module tb_injetor_seq;

  localparam int W  = 9;
  localparam int IW = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  entrada;
  logic          entrada_valida;
  logic [1:0]    modo;
  logic [IW-1:0] n;
  logic          duplo;
  logic          disparo;
  logic [CW-1:0] periodo;
  logic          limpa_contagem;
  logic [W-1:0]  saida, saida4;
  logic          saida_valida, saida_valida4;
  logic          injetado, injetado4;
  logic [CW-1:0] contagem_erros;
  logic [3:0]    contagem_erros4;

  int checks = 0;
  int errors = 0;

  logic [15:0] seq [1024];
  int          m_k, m_pc, m_cnt, m_cnt4;
  bit          m_armed, m_valid, m_inj;
  logic [W-1:0] m_saida;

  always #5 clk = ~clk;

  injetor_seq #(.WIDTH(W), .CNTW(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .entrada(entrada), .entrada_valida(entrada_valida),
    .modo(modo), .n(n), .duplo(duplo), .disparo(disparo), .periodo(periodo),
    .limpa_contagem(limpa_contagem), .saida(saida), .saida_valida(saida_valida),
    .injetado(injetado), .contagem_erros(contagem_erros)
  );

  injetor_seq #(.WIDTH(W), .CNTW(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .entrada(entrada), .entrada_valida(entrada_valida),
    .modo(modo), .n(n), .duplo(duplo), .disparo(disparo), .periodo(periodo[3:0]),
    .limpa_contagem(limpa_contagem), .saida(saida4), .saida_valida(saida_valida4),
    .injetado(injetado4), .contagem_erros(contagem_erros4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mask_of(input int idx, input bit dup);
    logic [W-1:0] m;
    if (idx >= W) return '0;
    m = W'(1) << idx;
    if (dup) m = m | (W'(1) << ((idx + 1) % W));
    return m;
  endfunction

  // Behavioural reference, applied with the inputs sampled at the clock edge.
  task automatic model_step();
    bit           fire;
    int           idx, l;
    logic [W-1:0] msk;
    if (!rst_n) begin
      m_saida = '0; m_valid = 0; m_inj = 0; m_cnt = 0; m_cnt4 = 0;
      m_armed = 0; m_pc = 0; m_k = 0;
      return;
    end
    fire = 0;
    idx  = int'(n);
    if (entrada_valida) begin
      l = int'(seq[m_k]);
      m_k++;
      case (modo)
        2'd1: fire = m_armed || disparo;
        2'd2: begin
          if (periodo == 0) m_pc = 0;
          else if (m_pc >= int'(periodo) - 1) begin fire = 1; m_pc = 0; end
          else m_pc++;
        end
        2'd3: begin
          fire = (l >> 12) == 0;
          idx  = l % (1 << IW);
          if (idx >= W) idx -= W;
        end
        default: fire = 0;
      endcase
      msk     = fire ? mask_of(idx, duplo) : '0;
      m_inj   = msk != 0;
      m_saida = entrada ^ msk;
      m_valid = 1;
    end else begin
      m_valid = 0;
      m_inj   = 0;
    end
    if (modo == 2'd1) begin
      if (entrada_valida && fire) m_armed = 0;
      else if (disparo) m_armed = 1;
    end else begin
      m_armed = 0;
    end
    if (modo != 2'd2) m_pc = 0;
    if (limpa_contagem) begin
      m_cnt = 0; m_cnt4 = 0;
    end else if (m_inj) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("saida", saida, m_saida);
    chk("saida_valida", saida_valida, m_valid);
    chk("injetado", injetado, m_inj);
    chk("contagem", contagem_erros, m_cnt);
    chk("saida_w4", saida4, m_saida);
    chk("contagem_w4", contagem_erros4, m_cnt4);
  endtask

  task automatic send(input logic [W-1:0] d);
    entrada = d;
    entrada_valida = 1'b1;
    cyc();
    entrada_valida = 1'b0;
  endtask

  task automatic pulse_disparo();
    disparo = 1'b1;
    cyc();
    disparo = 1'b0;
  endtask

  initial begin
    logic [15:0]  lf;
    logic [W-1:0] d;
    lf = 16'hACE1;
    for (int k = 0; k < 1024; k++) begin
      seq[k] = lf;
      lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
    end

    rst_n = 1'b0; entrada = 9'h155; entrada_valida = 1'b1; modo = 2'd3; n = 4'd0;
    duplo = 1'b0; disparo = 1'b0; periodo = 16'd0; limpa_contagem = 1'b0;
    cyc();
    cyc();
    chk("rst_saida", saida, 9'h000);
    chk("rst_valida", saida_valida, 1'b0);
    chk("rst_inj", injetado, 1'b0);
    chk("rst_cnt", contagem_erros, 16'd0);
    rst_n = 1'b1;
    entrada_valida = 1'b0;
    modo = 2'd0;
    cyc();

    // Off: pass-through
    send(9'h0A5); chk("off_a5", saida, 9'h0A5); chk("off_inj", injetado, 1'b0);
    send(9'h1FF); chk("off_1ff", saida, 9'h1FF);
    send(9'h000); chk("off_000", saida, 9'h000); chk("off_cnt", contagem_erros, 16'd0);
    cyc(); chk("off_idle_hold", saida, 9'h000); chk("off_idle_valid", saida_valida, 1'b0);

    // Single-shot, n=3
    modo = 2'd1; n = 4'd3; duplo = 1'b0;
    pulse_disparo();
    send(9'h0A5); chk("ss_first", saida, 9'h0AD); chk("ss_first_inj", injetado, 1'b1);
    send(9'h0A5); chk("ss_second", saida, 9'h0A5); chk("ss_second_inj", injetado, 1'b0);
    chk("ss_cnt", contagem_erros, 16'd1);

    // Single-shot, n=8 double with wrap-around
    n = 4'd8; duplo = 1'b1;
    pulse_disparo();
    send(9'h0A5); chk("ss_wrap", saida, 9'h1A4); chk("ss_wrap_cnt", contagem_erros, 16'd2);
    duplo = 1'b0;

    // Periodic, periodo=4
    modo = 2'd2; periodo = 16'd4; n = 4'd0;
    for (int i = 1; i <= 12; i++) begin
      d = W'($urandom);
      send(d);
      chk("per4_word", saida, d ^ ((i % 4 == 0) ? 9'h001 : 9'h000));
      repeat ($urandom_range(0, 2)) cyc();
    end
    chk("per4_cnt", contagem_erros, 16'd5);

    periodo = 16'd0;
    for (int i = 0; i < 6; i++) begin
      d = W'($urandom);
      send(d);
      chk("per0_word", saida, d);
    end
    chk("per0_cnt", contagem_erros, 16'd5);

    // Out-of-range index: armed clears without corrupting
    modo = 2'd1; n = 4'd9;
    pulse_disparo();
    send(9'h0F0); chk("oor_word", saida, 9'h0F0); chk("oor_inj", injetado, 1'b0);
    n = 4'd3;
    send(9'h0F0); chk("oor_disarmed", saida, 9'h0F0); chk("oor_cnt", contagem_erros, 16'd5);

    // Saturation of the narrow counter
    modo = 2'd2; periodo = 16'd1; n = 4'd0;
    for (int i = 0; i < 20; i++) send(W'($urandom));
    chk("sat_cnt4", contagem_erros4, 4'hF);
    chk("sat_cnt16", contagem_erros, 16'd25);

    // Clear wins over a simultaneous increment
    limpa_contagem = 1'b1;
    send(9'h055);
    limpa_contagem = 1'b0;
    chk("clr_inj", injetado, 1'b1);
    chk("clr_cnt", contagem_erros, 16'd0);
    chk("clr_cnt4", contagem_erros4, 4'h0);

    // Pseudo-random with a reset in the middle of the stream
    modo = 2'd3;
    for (int i = 0; i < 200; i++) begin
      duplo = 1'($urandom);
      n     = IW'($urandom);
      send(W'($urandom));
      if ($urandom_range(0, 3) == 0) cyc();
      if (i == 100) begin
        rst_n = 1'b0;
        entrada_valida = 1'b1;
        cyc();
        rst_n = 1'b1;
        entrada_valida = 1'b0;
        chk("mid_rst_cnt", contagem_erros, 16'd0);
      end
    end
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/injetor_seq.md
Name: injetor_seq

Overview:
Clocked, parametrised error injector for parity-protected data words. It sits between a parity encoder and a parity checker in the fault-injection test path. It registers the word stream with one cycle of latency and flips one or two bits of selected words. Which words are corrupted depends on the selected mode: off, single-shot, periodic, or pseudo-random. It also keeps a count of injected errors for comparison against the checker's detections.

Parameters:
WIDTH, 9, word width in bits (data plus parity); legal range 2..64
IDXW, $clog2(WIDTH), width of the bit-index inputs
CNTW, 16, width of the period input and the error counter

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  synchronous active-low reset
entrada  input  WIDTH  incoming word
entrada_valida  input  1  entrada carries a word this cycle
modo  input  2  mode: 0 off, 1 single-shot, 2 periodic, 3 pseudo-random
n  input  IDXW  bit index to flip (modes 1 and 2)
duplo  input  1  also flip bit (idx+1) mod WIDTH, giving a double-bit error
disparo  input  1  one-cycle pulse that arms single-shot mode
periodo  input  CNTW  periodic mode: inject every periodo-th valid word
limpa_contagem  input  1  clears contagem_erros
saida  output  WIDTH  registered output word
saida_valida  output  1  saida carries a word
injetado  output  1  word on saida was corrupted; aligned with saida
contagem_erros  output  CNTW  number of corrupted words; saturating

Behaviour:
- Reset, applied while rst_n=0 on a clock edge:
  - saida=0, saida_valida=0, injetado=0, contagem_erros=0
  - armed=0, period counter=0, LFSR=16'hACE1
  - A word in flight when reset is applied is dropped.
- Latency is one cycle.
  - saida_valida(t+1) = entrada_valida(t).
  - When entrada_valida=0: saida holds its previous value, saida_valida=0, injetado=0.
  - There is no backpressure; every valid word is accepted.
- Injection mask for a word at index idx:
  - mask = (1<<idx), OR'd with (1<<((idx+1) mod WIDTH)) when duplo=1.
  - saida = entrada ^ mask.
  - If idx >= WIDTH, mask=0, the word passes unchanged, injetado=0 and the counter does not change.
- Decision logic, evaluated only on cycles with entrada_valida=1; mode and controls are sampled in the same cycle:
  - modo=0: never inject. armed and the period counter are cleared.
  - modo=1 (single-shot):
    - disparo=1 sets armed. disparo while already armed is ignored.
    - The first valid word with armed=1, or with disparo=1 in that same cycle, is injected at idx=n; armed then clears.
    - Changing modo away from 1 clears armed.
  - modo=2 (periodic):
    - The period counter increments on each valid word.
    - When counter==periodo-1, the word is injected at idx=n and the counter returns to 0.
    - periodo=0 means never inject; the counter stays 0.
    - Changing periodo mid-run: if counter >= the new periodo-1, the next valid word is injected and the counter wraps.
    - The counter is cleared whenever modo!=2.
  - modo=3 (pseudo-random):
    - 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting left with the feedback into bit 0; it advances once per valid word, in all modes.
    - A word is injected when LFSR[15:12]==0, using the pre-advance LFSR value.
    - idx = LFSR[IDXW-1:0], minus WIDTH if that value is >= WIDTH.
- contagem_erros:
  - Increments on each corrupted word, in the same cycle injetado is registered.
  - Saturates at all-ones.
  - limpa_contagem=1 clears it, and takes priority over an increment in the same cycle.

Test Plan:
- Reset: drive rst_n=0 for 2 clocks with entrada_valida=1 -> saida=0, saida_valida=0, injetado=0, contagem_erros=0. After release, LFSR=16'hACE1.
- Off, pass-through: modo=0, stream 9'h0A5, 9'h1FF, 9'h000 -> same values appear one cycle later, injetado=0 throughout, contagem_erros stays 0.
- Single-shot, n=3, duplo=0:
  - Pulse disparo, then send 9'h0A5 twice -> first output 9'h0AD with injetado=1, second output 9'h0A5 with injetado=0, contagem_erros=1.
  - Repeat with n=8, duplo=1 -> output 9'h1A4 (bits 8 and 0 flipped, wrap-around).
- Periodic, periodo=4, n=0, 12 valid words with gaps of idle cycles -> words 4, 8 and 12 have bit 0 flipped, contagem_erros=3.
  - With periodo=0 -> no injections.
- Out-of-range and counter behaviour:
  - n=9 in single-shot mode -> word unchanged, injetado=0, armed clears.
  - Preload the counter near the top in a CNTW=4 build and inject 20 times -> contagem_erros saturates at 4'hF.
  - limpa_contagem asserted together with an injection -> counter reads 0.
- Pseudo-random: 200 valid words against a reference-model LFSR seeded 16'hACE1 -> every injection flag, index and output word matches the model.
  - Assert rst_n=0 mid-stream -> LFSR reseeds and the injection sequence repeats from the start.
